// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, exception codes and bus layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 87;
   localparam int MS_TO_WS_BUS_WD = 79;
   localparam int MS_FORWARD_WD   = 41;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;
   localparam logic [5:0] ECODE_IPE  = 6'h0E;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   // EX -> MEM bus. ld_op bit order: {ld_w, ld_b, ld_bu, ld_h, ld_hu}.
   typedef struct packed {
      logic        mem_req;
      logic [4:0]  ld_op;
      logic [1:0]  addr_lo;
      logic        ex;
      logic [5:0]  ecode;
      logic        esubcode;
      logic        ertn;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_bus_t;

   // MEM -> WB bus.
   typedef struct packed {
      logic        ertn;
      logic        esubcode;
      logic [5:0]  ecode;
      logic        ex;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ws_bus_t;

   // MEM -> ID/EX forwarding and hazard info.
   typedef struct packed {
      logic        load_wait;
      logic        ex_or_ertn;
      logic [31:0] result;
      logic [4:0]  dest;
      logic        gr_we;
      logic        valid;
   } fwd_t;

   function automatic logic is_load(input logic [4:0] op);
      return |op;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half/word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align (
   input  logic [4:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed lane, then extend according to the load flavour.
   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
      data     = rdata;
      if (op[3])      data = {{24{byte_sel[7]}}, byte_sel};
      else if (op[2]) data = {24'h000000, byte_sel};
      else if (op[1]) data = {{16{half_sel[15]}}, half_sel};
      else if (op[0]) data = {16'h0000, half_sel};
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: collects the data-SRAM response owed to EX's request, aligns load data, hands it to WB.
// Latency: 0 extra cycles when data_ok lands in the first MEM cycle, otherwise waits for it.
// Backpressure: ms_allowin low while a response is owed or WB stalls; early responses parked in data_buf.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int CANCEL_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       final_ex,
   input  logic                       back_ertn_flush,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_FORWARD_WD-1:0]   ms_forward,
   output logic                       ms_to_es_ex
);

   localparam logic [CANCEL_W:0] CANCEL_MAX = {1'b0, {CANCEL_W{1'b1}}};
   localparam logic [CANCEL_W:0] CANCEL_ONE = {{CANCEL_W{1'b0}}, 1'b1};

   es_bus_t             es_bus;
   es_bus_t             ms_bus;
   ws_bus_t             ws_bus;
   fwd_t                fwd;

   logic                ms_valid;
   logic                got_resp;
   logic                buf_valid;
   logic [31:0]         data_buf;
   logic [CANCEL_W-1:0] cancel_cnt;
   logic [CANCEL_W-1:0] cancel_cnt_next;
   logic [CANCEL_W:0]   cancel_sum;

   logic                flush;
   logic                orphan_ok;
   logic                owned_ok;
   logic                ms_ready_go;
   logic                inc_cur;
   logic                inc_es;
   logic [31:0]         load_src;
   logic [31:0]         load_data;
   logic [31:0]         final_result;

   assign es_bus = es_bus_t'(es_to_ms_bus);
   assign flush  = final_ex | back_ertn_flush;

   // While orphans are pending every data_ok belongs to a cancelled request.
   assign orphan_ok   = data_sram_data_ok & (cancel_cnt != '0);
   assign owned_ok    = data_sram_data_ok & (cancel_cnt == '0) & ms_valid & ms_bus.mem_req & ~got_resp;
   assign ms_ready_go = ~ms_bus.mem_req | got_resp | owned_ok;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
   assign ms_to_ws_valid = ms_valid & ms_ready_go;

   // A flush cancels the MEM entry's pending response and any request EX already
   // had accepted: that response is owed whether or not MEM takes the entry this cycle.
   assign inc_cur = ms_valid & ms_bus.mem_req & ~got_resp & ~owned_ok;
   assign inc_es  = es_to_ms_valid & es_bus.mem_req;

   // Stage valid: a flush beats a same-cycle handover from EX.
   always_ff @(posedge clk) begin
      if (reset)           ms_valid <= 1'b0;
      else if (flush)      ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;
   end

   // Bus register loads whenever EX hands over an entry.
   always_ff @(posedge clk) begin
      if (reset)                             ms_bus <= '0;
      else if (ms_allowin && es_to_ms_valid) ms_bus <= es_bus;
   end

   // Response flags: cleared on a new entry, set when the owned response arrives.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         got_resp  <= 1'b0;
         buf_valid <= 1'b0;
      end else if (ms_allowin) begin
         got_resp  <= 1'b0;
         buf_valid <= 1'b0;
      end else if (owned_ok) begin
         got_resp  <= 1'b1;
         buf_valid <= 1'b1;
      end
   end

   // Park the owned response so a WB stall never loses it.
   always_ff @(posedge clk) begin
      if (reset)         data_buf <= '0;
      else if (owned_ok) data_buf <= data_sram_rdata;
   end

   // Orphan accounting: add cancelled requests on a flush, retire one per orphan response.
   always_comb begin
      cancel_sum = {1'b0, cancel_cnt};
      if (flush) begin
         cancel_sum = cancel_sum + {{CANCEL_W{1'b0}}, inc_cur} + {{CANCEL_W{1'b0}}, inc_es};
      end
      if (orphan_ok) begin
         cancel_sum = cancel_sum - CANCEL_ONE;
      end
      cancel_cnt_next = (cancel_sum > CANCEL_MAX) ? CANCEL_MAX[CANCEL_W-1:0] : cancel_sum[CANCEL_W-1:0];
   end

   // Orphan counter register; more outstanding orphans than it can hold is a design error.
   always_ff @(posedge clk) begin
      if (reset) begin
         cancel_cnt <= '0;
      end else begin
         assert (cancel_sum <= CANCEL_MAX);
         cancel_cnt <= cancel_cnt_next;
      end
   end

   // Same-cycle response passes straight through; later ones come from the buffer.
   always_comb begin
      load_src = 32'h0;
      if (owned_ok)       load_src = data_sram_rdata;
      else if (buf_valid) load_src = data_buf;
   end

   load_align u_load_align (
      .op      (ms_bus.ld_op),
      .addr_lo (ms_bus.addr_lo),
      .rdata   (load_src),
      .data    (load_data)
   );

   assign final_result = is_load(ms_bus.ld_op) ? load_data : ms_bus.result;

   // Assemble the WB and forwarding buses.
   always_comb begin
      ws_bus.ertn         = ms_bus.ertn;
      ws_bus.esubcode     = ms_bus.esubcode;
      ws_bus.ecode        = ms_bus.ecode;
      ws_bus.ex           = ms_bus.ex;
      ws_bus.gr_we        = ms_bus.gr_we;
      ws_bus.dest         = ms_bus.dest;
      ws_bus.final_result = final_result;
      ws_bus.pc           = ms_bus.pc;

      fwd.load_wait  = ms_valid & ms_bus.mem_req & ~ms_ready_go;
      fwd.ex_or_ertn = ms_valid & (ms_bus.ex | ms_bus.ertn);
      fwd.result     = final_result;
      fwd.dest       = ms_bus.dest;
      fwd.gr_we      = ms_bus.gr_we;
      fwd.valid      = ms_valid;
   end

   assign ms_to_ws_bus = ws_bus;
   assign ms_forward   = fwd;
   assign ms_to_es_ex  = ms_valid & (ms_bus.ex | ms_bus.ertn);

endmodule
